// File: rtl/spart_pkg.sv
// spart_pkg: register map, baud encodings, divisor table and FSM states for spart_driver.
// Latency: n/a (constants and a pure combinational helper).
// Backpressure: n/a.
package spart_pkg;

  // SPART register addresses
  localparam logic [1:0] ADDR_BUF    = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam logic [1:0] ADDR_DIV_LO = 2'b10;
  localparam logic [1:0] ADDR_DIV_HI = 2'b11;

  // br_cfg encodings
  localparam logic [1:0] BR_4800  = 2'b00;
  localparam logic [1:0] BR_9600  = 2'b01;
  localparam logic [1:0] BR_19200 = 2'b10;
  localparam logic [1:0] BR_38400 = 2'b11;

  // Baud divisors for a 50 MHz clock: round(50e6 / (16 * baud)) - 1
  localparam logic [15:0] DIV_4800  = 16'h028A;
  localparam logic [15:0] DIV_9600  = 16'h0145;
  localparam logic [15:0] DIV_19200 = 16'h00A2;
  localparam logic [15:0] DIV_38400 = 16'h0050;

  typedef enum logic [2:0] {
    CFG_LO,
    CFG_HI,
    WAIT_RX,
    READ,
    WAIT_TX,
    WRITE
  } state_t;

  // Map a baud select to its 16-bit divisor.
  function automatic logic [15:0] divisor_for(input logic [1:0] sel);
    logic [15:0] div;
    case (sel)
      BR_4800:  div = DIV_4800;
      BR_9600:  div = DIV_9600;
      BR_19200: div = DIV_19200;
      default:  div = DIV_38400;
    endcase
    return div;
  endfunction

endpackage

// File: rtl/spart_echo_fifo.sv
// spart_echo_fifo: small synchronous FIFO holding received bytes awaiting echo.
// Latency: a pushed byte is visible on rdata the cycle after the push.
// Backpressure: push ignored when full, pop ignored when empty; caller checks full/empty.
module spart_echo_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push && !full) begin
        mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        wr_ptr_q                <= wr_ptr_q + (AW+1)'(1);
      end
      if (pop && !empty) begin
        rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
    end
  end

  assign rdata = mem_q[rd_ptr_q[AW-1:0]];
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/spart_driver.sv
// spart_driver: programs the SPART baud divisor, then echoes every received byte back out.
// Latency: one bus access per cycle; read-to-write echo takes 2 cycles when tbr is already high.
// Backpressure: waits on rda/tbr; SPART_DRV_FIFO_EN adds an echo FIFO so reads continue while tbr is low.
module spart_driver
  import spart_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  input  logic       rda,
  input  logic       tbr,
  inout  wire  [7:0] databus
);

  // The divisor table is only valid for a 50 MHz clock; the FIFO needs a power-of-2 depth.
  if (CLK_HZ != 50000000) begin : g_bad_clk
    $error("spart_driver: divisor table assumes CLK_HZ = 50000000");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("spart_driver: FIFO_DEPTH must be a power of 2 and at least 2");
  end

  state_t      state_q;
  logic [1:0]  sel_q;     // baud select whose low byte was just written
  logic [1:0]  cfg_q;     // baud select currently programmed into the SPART
  logic [15:0] div_w;
  logic [7:0]  dout_w;
  logic [7:0]  wr_byte_w;

`ifdef SPART_DRV_FIFO_EN
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_rdata;

  spart_echo_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_echo_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (state_q == READ),
    .pop   (state_q == WRITE),
    .wdata (databus),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign wr_byte_w = fifo_rdata;
`else
  logic [7:0] rx_q;

  assign wr_byte_w = rx_q;
`endif

  // The high byte comes from the select latched with the low byte, so a
  // mid-sequence br_cfg change never yields a mixed divisor; WAIT_RX then
  // sees the mismatch and reprograms.
  assign div_w = divisor_for((state_q == CFG_HI) ? sel_q : br_cfg);

  // Sequencer: divisor programming, then the receive/echo loop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CFG_LO;
      sel_q   <= BR_4800;
      cfg_q   <= BR_4800;
`ifndef SPART_DRV_FIFO_EN
      rx_q    <= 8'h00;
`endif
    end else begin
      case (state_q)
        CFG_LO: begin
          sel_q   <= br_cfg;
          state_q <= CFG_HI;
        end
        CFG_HI: begin
          cfg_q   <= sel_q;
          state_q <= WAIT_RX;
        end
        WAIT_RX: begin
          if (br_cfg != cfg_q) begin
            state_q <= CFG_LO;
`ifdef SPART_DRV_FIFO_EN
          end else if (rda && !fifo_full) begin
            state_q <= READ;
          end else if (!fifo_empty && tbr) begin
            state_q <= WRITE;
`else
          end else if (rda) begin
            state_q <= READ;
`endif
          end
        end
        READ: begin
`ifdef SPART_DRV_FIFO_EN
          state_q <= WAIT_RX;
`else
          rx_q    <= databus;
          state_q <= WAIT_TX;
`endif
        end
        WAIT_TX: begin
          if (tbr) begin
            state_q <= WRITE;
          end
        end
        WRITE: begin
          state_q <= WAIT_RX;
        end
        default: begin
          state_q <= CFG_LO;
        end
      endcase
    end
  end

  // Bus controls decode the state register; reset forces the idle pattern at once so an access in progress is dropped.
  always_comb begin
    iocs   = 1'b0;
    iorw   = 1'b1;
    ioaddr = ADDR_BUF;
    dout_w = 8'h00;
    case (state_q)
      CFG_LO: begin
        iocs   = 1'b1;
        iorw   = 1'b0;
        ioaddr = ADDR_DIV_LO;
        dout_w = div_w[7:0];
      end
      CFG_HI: begin
        iocs   = 1'b1;
        iorw   = 1'b0;
        ioaddr = ADDR_DIV_HI;
        dout_w = div_w[15:8];
      end
      READ: begin
        iocs   = 1'b1;
        iorw   = 1'b1;
        ioaddr = ADDR_BUF;
      end
      WRITE: begin
        iocs   = 1'b1;
        iorw   = 1'b0;
        ioaddr = ADDR_BUF;
        dout_w = wr_byte_w;
      end
      default: begin
        iocs   = 1'b0;
        iorw   = 1'b1;
        ioaddr = ADDR_BUF;
      end
    endcase
    if (rst) begin
      iocs   = 1'b0;
      iorw   = 1'b1;
      ioaddr = ADDR_BUF;
    end
  end

  assign databus = (iocs && !iorw) ? dout_w : 8'hzz;

endmodule

// File: tb/tb_spart_driver.sv
// tb_spart_driver: directed vectors for spart_driver with a logging bus model.
// Latency: checks exact cycle spacing between reads and echo writes.
// Backpressure: exercises tbr held low, rda ignored while busy and FIFO full (SPART_DRV_FIFO_EN).
module tb_spart_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] br_cfg = 2'b01;
  logic       rda = 1'b0;
  logic       tbr = 1'b0;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  wire  [7:0] databus;
  logic [7:0] rd_val = 8'h00;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct packed {
    logic        rw;
    logic [1:0]  addr;
    logic [7:0]  data;
    logic [31:0] cyc;
  } acc_t;

  acc_t log_q[$];

  always #5 clk = ~clk;

  // SPART side of the bus: returns rd_val on buffer reads.
  assign databus = (iocs && iorw && (ioaddr == 2'b00)) ? rd_val : 8'hzz;

  spart_driver dut (
    .clk     (clk),
    .rst     (rst),
    .br_cfg  (br_cfg),
    .iocs    (iocs),
    .iorw    (iorw),
    .ioaddr  (ioaddr),
    .rda     (rda),
    .tbr     (tbr),
    .databus (databus)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Log every bus access mid-cycle.
  always @(negedge clk) begin
    if (iocs) log_q.push_back('{rw: iorw, addr: ioaddr, data: databus, cyc: cyc});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_rda();
    rda = 1'b1;
    step(1);
    rda = 1'b0;
  endtask

  function automatic acc_t get(input int idx);
    acc_t e;
    e = '0;
    if (idx < log_q.size()) e = log_q[idx];
    return e;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   mark;
    int   t0;
    int   nrd;
    int   nwr;
    bit   found;
    acc_t e0, e1, e2, e3;
    logic [7:0] wdat [$];

    // Reset: idle bus, no accesses
    step(3);
    chk("rst_iocs", iocs, 1'b0);
    chk("rst_iorw", iorw, 1'b1);
    chk("rst_ioaddr", ioaddr, 2'b00);
    chk("rst_noacc", log_q.size(), 0);

    // Divisor programming at 9600 baud
    mark = log_q.size();
    rst = 1'b0;
    step(6);
    chk("cfg_count", log_q.size() - mark, 2);
    e0 = get(mark);
    e1 = get(mark + 1);
    chk("cfg_lo_rw", e0.rw, 1'b0);
    chk("cfg_lo_addr", e0.addr, 2'b10);
    chk("cfg_lo_data", e0.data, 8'h45);
    chk("cfg_hi_rw", e1.rw, 1'b0);
    chk("cfg_hi_addr", e1.addr, 2'b11);
    chk("cfg_hi_data", e1.data, 8'h01);
    chk("cfg_back2back", e1.cyc, e0.cyc + 1);
    chk("cfg_idle", iocs, 1'b0);

    // Echo with tbr already high
    mark = log_q.size();
    rd_val = 8'h41;
    tbr = 1'b1;
    pulse_rda();
    step(6);
    chk("echo_count", log_q.size() - mark, 2);
    e0 = get(mark);
    e1 = get(mark + 1);
    chk("echo_rd_rw", e0.rw, 1'b1);
    chk("echo_rd_addr", e0.addr, 2'b00);
    chk("echo_wr_rw", e1.rw, 1'b0);
    chk("echo_wr_addr", e1.addr, 2'b00);
    chk("echo_wr_data", e1.data, 8'h41);
    chk("echo_latency", e1.cyc, e0.cyc + 2);

    // tbr held low for 20 cycles after a read
    mark = log_q.size();
    tbr = 1'b0;
    rd_val = 8'h5A;
    pulse_rda();
    step(5);
`ifndef SPART_DRV_FIFO_EN
    rd_val = 8'h77;
    pulse_rda();
`endif
    step(15);
    chk("tbr_low_count", log_q.size() - mark, 1);
    e0 = get(mark);
    chk("tbr_low_rd", e0.rw, 1'b1);
    chk("tbr_low_rdata", e0.data, 8'h5A);
    t0 = cyc;
    tbr = 1'b1;
    step(4);
    chk("tbr_rise_count", log_q.size() - mark, 2);
    e1 = get(mark + 1);
    chk("tbr_rise_rw", e1.rw, 1'b0);
    chk("tbr_rise_data", e1.data, 8'h5A);
    chk("tbr_rise_cyc", e1.cyc, t0 + 1);

    // Baud change with rda in the same cycle: reconfigure first
    mark = log_q.size();
    rd_val = 8'hC3;
    br_cfg = 2'b11;
    rda = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1);
      for (int j = mark; j < log_q.size(); j++) begin
        if (log_q[j].rw) found = 1'b1;
      end
    end
    rda = 1'b0;
    chk("reconf_rd_seen", found, 1'b1);
    step(4);
    chk("reconf_count", log_q.size() - mark, 4);
    e0 = get(mark);
    e1 = get(mark + 1);
    e2 = get(mark + 2);
    e3 = get(mark + 3);
    chk("reconf_lo", {e0.rw, e0.addr, e0.data}, {1'b0, 2'b10, 8'h50});
    chk("reconf_hi", {e1.rw, e1.addr, e1.data}, {1'b0, 2'b11, 8'h00});
    chk("reconf_rd", {e2.rw, e2.addr, e2.data}, {1'b1, 2'b00, 8'hC3});
    chk("reconf_wr", {e3.rw, e3.addr, e3.data}, {1'b0, 2'b00, 8'hC3});

    // Reset during a write aborts it and restarts configuration
    mark = log_q.size();
    tbr = 1'b0;
    rd_val = 8'h3C;
    pulse_rda();
    step(4);
    tbr = 1'b1;
    step(1);
    chk("wr_active_iocs", iocs, 1'b1);
    chk("wr_active_iorw", iorw, 1'b0);
    rst = 1'b1;
    step(1);
    chk("wr_abort_iocs", iocs, 1'b0);
    chk("wr_abort_iorw", iorw, 1'b1);
    chk("wr_abort_ioaddr", ioaddr, 2'b00);
    chk("wr_abort_nowrite", log_q.size() - mark, 1);
    step(1);
    mark = log_q.size();
    rst = 1'b0;
    step(6);
    chk("restart_count", log_q.size() - mark, 2);
    e0 = get(mark);
    e1 = get(mark + 1);
    chk("restart_lo", {e0.rw, e0.addr, e0.data}, {1'b0, 2'b10, 8'h50});
    chk("restart_hi", {e1.rw, e1.addr, e1.data}, {1'b0, 2'b11, 8'h00});

    // Five receive events while tbr is low
    mark = log_q.size();
    tbr = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      rd_val = 8'(i);
      pulse_rda();
      step(3);
    end
    nrd = 0;
    for (int j = mark; j < log_q.size(); j++) begin
      if (log_q[j].rw) nrd++;
    end
`ifdef SPART_DRV_FIFO_EN
    chk("burst_reads", nrd, 4);
`else
    chk("burst_reads", nrd, 1);
`endif
    tbr = 1'b1;
    step(12);
    nwr = 0;
    for (int j = mark; j < log_q.size(); j++) begin
      if (!log_q[j].rw) begin
        nwr++;
        wdat.push_back(log_q[j].data);
      end
    end
`ifdef SPART_DRV_FIFO_EN
    chk("burst_writes", nwr, 4);
    for (int k = 0; k < 4; k++) begin
      chk("burst_order", (k < wdat.size()) ? wdat[k] : 8'hxx, 8'(k + 1));
    end
`else
    chk("burst_writes", nwr, 1);
    chk("burst_data", (wdat.size() > 0) ? wdat[0] : 8'hxx, 8'h01);
`endif
    chk("final_idle", iocs, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
